cl_mem_init_ctrl: RTL and testbench

Write-side controller for the interpreter's two code-length memories: the literal/length memory (`cl_cl_ll_mem`, 286 entries) and the distance memory (`cl_cl_distance_mem`, 30 entries). After reset, or on request between deflate blocks, it sweeps both memories to zero. It then hands the write ports to the interpreter's code-length decoder through a valid/ready handshake, routing each write to the selected memory and range-checking the address.

---
 rtl/cl_mem_init_ctrl_if.sv | 39 +++
 rtl/cl_mem_init_ctrl.sv | 150 +++++++++++++++
 tb/tb_cl_mem_init_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cl_mem_init_ctrl_if.sv
// Write-side bundle between the code-length decoder, the controller and the
// two code-length memories (literal/length and distance).
interface cl_mem_init_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 4
);
    // Decoder write request handshake
    logic              wr_valid;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    // Literal/length memory write port
    logic              ll_we;
    logic [ADDR_W-1:0] ll_addr;
    logic [DATA_W-1:0] ll_wdata;

    // Distance memory write port
    logic              dist_we;
    logic [ADDR_W-1:0] dist_addr;
    logic [DATA_W-1:0] dist_wdata;

    // Decoder / environment side
    modport master (
        output wr_valid, wr_sel, wr_addr, wr_data,
        input  wr_ready,
        input  ll_we, ll_addr, ll_wdata,
        input  dist_we, dist_addr, dist_wdata
    );

    // Controller side
    modport slave (
        input  wr_valid, wr_sel, wr_addr, wr_data,
        output wr_ready,
        output ll_we, ll_addr, ll_wdata,
        output dist_we, dist_addr, dist_wdata
    );
endinterface

// File: rtl/cl_mem_init_ctrl.sv
// Code-length memory write controller: zero-sweeps both memories after reset
// or on request, then forwards range-checked decoder writes to the selected
// memory with one cycle of latency.
module cl_mem_init_ctrl #(
    parameter int LL_DEPTH   = 286,
    parameter int DIST_DEPTH = 30,
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_req,
    cl_mem_init_ctrl_if.slave   wif,
    output logic                busy,
    output logic                clear_done,
    output logic                err_oob
);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    localparam logic [ADDR_W:0]   LL_LIM   = (ADDR_W+1)'(LL_DEPTH);
    localparam logic [ADDR_W:0]   DIST_LIM = (ADDR_W+1)'(DIST_DEPTH);
    localparam logic [ADDR_W-1:0] LL_LAST  = ADDR_W'(LL_DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ll_we_q, ll_we_d;
    logic [ADDR_W-1:0] ll_addr_q, ll_addr_d;
    logic [DATA_W-1:0] ll_wdata_q, ll_wdata_d;
    logic              dist_we_q, dist_we_d;
    logic [ADDR_W-1:0] dist_addr_q, dist_addr_d;
    logic [DATA_W-1:0] dist_wdata_q, dist_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // The state register runs one cycle ahead of the registered port outputs,
    // so the controller is truly idle only once the last sweep write has left
    // the output registers (busy_q low).
    logic idle;
    logic accept;
    logic in_range;

    assign idle         = (state_q == ST_READY) && !busy_q;
    assign wif.wr_ready = idle && !clear_req;
    assign accept       = wif.wr_valid && wif.wr_ready;
    assign in_range     = wif.wr_sel ? ({1'b0, wif.wr_addr} < DIST_LIM)
                                     : ({1'b0, wif.wr_addr} < LL_LIM);

    // Next-state and next-output logic for sweep and write forwarding
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ll_we_d      = 1'b0;
        ll_addr_d    = '0;
        ll_wdata_d   = '0;
        dist_we_d    = 1'b0;
        dist_addr_d  = '0;
        dist_wdata_d = '0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        err_d        = err_q;

        case (state_q)
            ST_CLEAR: begin
                busy_d    = 1'b1;
                ll_we_d   = 1'b1;
                ll_addr_d = cnt_q;
                if ({1'b0, cnt_q} < DIST_LIM) begin
                    dist_we_d   = 1'b1;
                    dist_addr_d = cnt_q;
                end
                if (cnt_q == LL_LAST) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                // Final sweep write is on the ports now; pulse done next cycle.
                done_d = busy_q;
                if (idle && clear_req) begin
                    // Address 0 is issued immediately so the sweep starts with busy.
                    state_d   = ST_CLEAR;
                    cnt_d     = ADDR_W'(1);
                    busy_d    = 1'b1;
                    ll_we_d   = 1'b1;
                    dist_we_d = 1'b1;
                end else if (accept) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else if (wif.wr_sel) begin
                        dist_we_d    = 1'b1;
                        dist_addr_d  = wif.wr_addr;
                        dist_wdata_d = wif.wr_data;
                    end else begin
                        ll_we_d    = 1'b1;
                        ll_addr_d  = wif.wr_addr;
                        ll_wdata_d = wif.wr_data;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    // State, sweep counter and registered output stage
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= '0;
            ll_we_q      <= 1'b0;
            ll_addr_q    <= '0;
            ll_wdata_q   <= '0;
            dist_we_q    <= 1'b0;
            dist_addr_q  <= '0;
            dist_wdata_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ll_we_q      <= ll_we_d;
            ll_addr_q    <= ll_addr_d;
            ll_wdata_q   <= ll_wdata_d;
            dist_we_q    <= dist_we_d;
            dist_addr_q  <= dist_addr_d;
            dist_wdata_q <= dist_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign wif.ll_we      = ll_we_q;
    assign wif.ll_addr    = ll_addr_q;
    assign wif.ll_wdata   = ll_wdata_q;
    assign wif.dist_we    = dist_we_q;
    assign wif.dist_addr  = dist_addr_q;
    assign wif.dist_wdata = dist_wdata_q;
    assign busy           = busy_q;
    assign clear_done     = done_q;
    assign err_oob        = err_q;

endmodule

// File: tb/tb_cl_mem_init_ctrl.sv
// Self-checking bench for cl_mem_init_ctrl: a timeline model of the sweep and
// write forwarding checked every cycle, plus directed literal checks.
module tb_cl_mem_init_ctrl;

    localparam int LL   = 286;
    localparam int DIST = 30;

    logic clk = 1'b0;
    logic reset;
    logic clear_req;
    logic busy, clear_done, err_oob;

    cl_mem_init_ctrl_if #(.ADDR_W(9), .DATA_W(4)) wif ();

    cl_mem_init_ctrl #(
        .LL_DEPTH  (LL),
        .DIST_DEPTH(DIST),
        .ADDR_W    (9),
        .DATA_W    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .wif       (wif),
        .busy      (busy),
        .clear_done(clear_done),
        .err_oob   (err_oob)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // Sweep address k appears in cycle sweep_start+k; k == LL is the done
    // cycle and from then on the block accepts writes.
    int  cyc = 0;
    int  sweep_start = 0;
    int  k;
    bit  mvalid = 0;
    bit  m_ready = 0;
    bit  acc;
    int  e_ll_we, e_ll_addr, e_ll_data, e_dist_we, e_dist_addr, e_dist_data;
    int  e_busy, e_done, e_err;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            mvalid = 1;
            sweep_start = cyc + 1;
            m_ready = 0;
            e_ll_we = 0; e_ll_addr = 0; e_ll_data = 0;
            e_dist_we = 0; e_dist_addr = 0; e_dist_data = 0;
            e_busy = 0; e_done = 0; e_err = 0;
        end else if (mvalid) begin
            acc = m_ready && !clear_req && wif.wr_valid;
            if (m_ready && clear_req) sweep_start = cyc;
            k = cyc - sweep_start;
            e_ll_we = 0; e_ll_addr = 0; e_ll_data = 0;
            e_dist_we = 0; e_dist_addr = 0; e_dist_data = 0;
            e_done = 0;
            if (k < LL) begin
                e_busy = 1; m_ready = 0;
                e_ll_we = 1; e_ll_addr = k;
                if (k < DIST) begin e_dist_we = 1; e_dist_addr = k; end
            end else begin
                e_busy = 0; m_ready = 1;
                e_done = (k == LL) ? 1 : 0;
                if (acc) begin
                    if (wif.wr_sel == 1'b0 && int'(wif.wr_addr) < LL) begin
                        e_ll_we = 1; e_ll_addr = int'(wif.wr_addr); e_ll_data = int'(wif.wr_data);
                    end else if (wif.wr_sel == 1'b1 && int'(wif.wr_addr) < DIST) begin
                        e_dist_we = 1; e_dist_addr = int'(wif.wr_addr); e_dist_data = int'(wif.wr_data);
                    end else begin
                        e_err = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (mvalid) begin
            chk("ll_we", int'(wif.ll_we), e_ll_we);
            chk("dist_we", int'(wif.dist_we), e_dist_we);
            chk("busy", int'(busy), e_busy);
            chk("clear_done", int'(clear_done), e_done);
            chk("err_oob", int'(err_oob), e_err);
            chk("wr_ready", int'(wif.wr_ready), (m_ready && !clear_req) ? 1 : 0);
            if (e_ll_we != 0) begin
                chk("ll_addr", int'(wif.ll_addr), e_ll_addr);
                chk("ll_wdata", int'(wif.ll_wdata), e_ll_data);
            end
            if (e_dist_we != 0) begin
                chk("dist_addr", int'(wif.dist_addr), e_dist_addr);
                chk("dist_wdata", int'(wif.dist_wdata), e_dist_data);
            end
            if (e_busy != 0) chk("dist_wdata_clear", int'(wif.dist_wdata), 0);
        end
    end

    // Shadow memories built from what the ports write
    int sh_ll [LL];
    int sh_dist [DIST];
    always @(negedge clk) begin
        if (wif.ll_we && int'(wif.ll_addr) < LL) sh_ll[wif.ll_addr] = int'(wif.ll_wdata);
        if (wif.dist_we && int'(wif.dist_addr) < DIST) sh_dist[wif.dist_addr] = int'(wif.dist_wdata);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr(input bit sel, input int addr, input int data);
        wif.wr_valid = 1'b1;
        wif.wr_sel   = sel;
        wif.wr_addr  = 9'(addr);
        wif.wr_data  = 4'(data);
        step(1);
    endtask

    // Counts port activity over n cycles; cycle 1 is the first negedge.
    task automatic measure(input int n, output int lln, output int distn,
                           output int done_at, output int donen, output int first_addr);
        lln = 0; distn = 0; done_at = 0; donen = 0; first_addr = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 1) first_addr = wif.ll_we ? int'(wif.ll_addr) : -1;
            if (wif.ll_we) lln++;
            if (wif.dist_we) distn++;
            if (clear_done) begin
                donen++;
                if (done_at == 0) done_at = i;
            end
        end
    endtask

    int lln, distn, done_at, donen, first_addr;
    bit found;

    initial begin
        reset = 1'b1; clear_req = 1'b0;
        wif.wr_valid = 1'b0; wif.wr_sel = 1'b0; wif.wr_addr = '0; wif.wr_data = '0;

        // Reset sweep
        step(2);
        reset = 1'b0;
        step(1);
        measure(300, lln, distn, done_at, donen, first_addr);
        chk("rst_first_addr", first_addr, 0);
        chk("rst_ll_count", lln, 286);
        chk("rst_dist_count", distn, 30);
        chk("rst_done_cycle", done_at, 287);
        chk("rst_done_count", donen, 1);
        step(1);
        chk("ready_after_sweep", int'(wif.wr_ready), 1);

        // Back-to-back writes
        wr(0, 5, 7);
        wr(1, 29, 3);
        wr(0, 285, 15);
        wif.wr_valid = 1'b0;
        step(2);
        chk("mem_ll5", sh_ll[5], 7);
        chk("mem_dist29", sh_dist[29], 3);
        chk("mem_ll285", sh_ll[285], 15);
        chk("err_after_good", int'(err_oob), 0);

        // Out-of-range writes
        wr(1, 30, 2);
        wr(0, 286, 5);
        wif.wr_valid = 1'b0;
        step(2);
        chk("err_after_oob", int'(err_oob), 1);

        // Simultaneous clear and write; write held until accepted
        clear_req = 1'b1;
        wif.wr_valid = 1'b1; wif.wr_sel = 1'b0; wif.wr_addr = 9'd10; wif.wr_data = 4'd9;
        #1 chk("ready_during_clear_req", int'(wif.wr_ready), 0);
        step(1);
        clear_req = 1'b0;
        done_at = 0; lln = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (wif.ll_we) lln++;
            if (clear_done) begin
                done_at = i;
                chk("ready_at_done", int'(wif.wr_ready), 1);
                break;
            end
        end
        chk("sim_done_cycle", done_at, 287);
        chk("sim_ll_count", lln, 286);
        @(posedge clk); #2;
        wif.wr_valid = 1'b0;
        @(negedge clk);
        chk("held_wr_we", int'(wif.ll_we), 1);
        chk("held_wr_addr", int'(wif.ll_addr), 10);
        chk("held_wr_data", int'(wif.ll_wdata), 9);
        step(1);
        chk("err_sticky", int'(err_oob), 1);
        chk("mem_ll5_cleared", sh_ll[5], 0);

        // Requests during CLEAR are ignored
        clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        lln = 0; distn = 0; done_at = 0; donen = 0;
        for (int i = 1; i <= 320; i++) begin
            @(negedge clk);
            if (i == 50) begin
                clear_req = 1'b1; wif.wr_valid = 1'b1;
                wif.wr_sel = 1'b0; wif.wr_addr = 9'd3; wif.wr_data = 4'd4;
            end
            if (i == 51) begin
                clear_req = 1'b0; wif.wr_valid = 1'b0;
            end
            if (wif.ll_we) lln++;
            if (wif.dist_we) distn++;
            if (clear_done) begin
                donen++;
                if (done_at == 0) done_at = i;
            end
        end
        chk("mid_ll_count", lln, 286);
        chk("mid_dist_count", distn, 30);
        chk("mid_done_count", donen, 1);
        chk("mid_done_cycle", done_at, 287);
        step(1);

        // Reset mid-sweep
        clear_req = 1'b1;
        step(1);
        clear_req = 1'b0;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wif.ll_we && int'(wif.ll_addr) == 100) begin
                found = 1;
                break;
            end
        end
        chk("reached_addr100", int'(found), 1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(1);
        measure(300, lln, distn, done_at, donen, first_addr);
        chk("rrst_first_addr", first_addr, 0);
        chk("rrst_ll_count", lln, 286);
        chk("rrst_done_cycle", done_at, 287);
        step(1);
        chk("err_cleared_by_reset", int'(err_oob), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
